// File: rtl/btod_req_initiator.sv
// btod_req_initiator: blockB-side initiator of the blockB->blockD req/ack channel.
// Commands are queued in a DEPTH-entry FIFO and issued one at a time as req/ack
// transactions; each ack payload is returned on the rsp rdy/vld port.
// Optional feature: define BTOD_REQ_TIMEOUT_EN to bound the ack wait to TIMEOUT cycles
// (timeout yields a zero response with rsp_err set and latches err_sticky).
module btod_req_initiator #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RSP_W   = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_vld,
    output logic                   cmd_rdy,
    input  logic [DATA_W-1:0]      cmd_data,
    output logic                   req,
    output logic [DATA_W-1:0]      req_data,
    input  logic                   ack,
    input  logic [RSP_W-1:0]       ack_data,
    output logic                   rsp_vld,
    input  logic                   rsp_rdy,
    output logic [RSP_W-1:0]       rsp_data,
    output logic                   rsp_err,
    output logic [$clog2(DEPTH):0] fifo_cnt,
    output logic                   err_sticky
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StHold, StGap} state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              req_q, req_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;
    logic              rsp_vld_q, rsp_vld_d;
    logic [RSP_W-1:0]  rsp_data_q, rsp_data_d;
    // Parking slot for an ack that arrives while the response register is still occupied.
    logic [RSP_W-1:0]  hold_q, hold_d;

    logic push;
    logic issue;
    logic rsp_take;
    logic rsp_full;

`ifdef BTOD_REQ_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            rsp_err_q, rsp_err_d;
    logic            err_sticky_q, err_sticky_d;
    logic            tmo_hit;

    // Counter holds the number of REQ cycles already spent; this is the TIMEOUT-th.
    assign tmo_hit    = (tmo_cnt_q == TmoW'(TIMEOUT - 1));
    assign rsp_err    = rsp_err_q;
    assign err_sticky = err_sticky_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign rsp_err        = 1'b0;
    assign err_sticky     = 1'b0;
`endif

    // Ready comes from the registered count, so a pop never frees a slot in the same cycle.
    assign cmd_rdy  = ~rst & (cnt_q < CntFull);
    assign push     = cmd_vld & cmd_rdy;
    assign rsp_take = rsp_vld_q & rsp_rdy;
    assign rsp_full = rsp_vld_q & ~rsp_rdy;
    assign issue    = (state_q == StIdle) && (cnt_q != '0) && !rsp_vld_q;

    assign req      = req_q;
    assign req_data = req_data_q;
    assign rsp_vld  = rsp_vld_q;
    assign rsp_data = rsp_data_q;
    assign fifo_cnt = cnt_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: one outstanding request, mandatory low cycle after each transaction.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (issue) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (ack) begin
                    state_d = rsp_full ? StHold : StGap;
                end
`ifdef BTOD_REQ_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d = StGap;
                end
`endif
            end
            StHold: begin
                if (!rsp_full) begin
                    state_d = StGap;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs and datapath next-state: request, response register, FIFO bookkeeping.
    always_comb begin
        req_d      = req_q;
        req_data_d = req_data_q;
        rsp_vld_d  = rsp_vld_q;
        rsp_data_d = rsp_data_q;
        hold_d     = hold_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
`ifdef BTOD_REQ_TIMEOUT_EN
        rsp_err_d    = rsp_err_q;
        err_sticky_d = err_sticky_q;
        tmo_cnt_d    = tmo_cnt_q;
`endif

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (issue) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !issue) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && issue) begin
            cnt_d = cnt_q - 1'b1;
        end

        // A handshake frees the register; a new response below may refill it at once.
        if (rsp_take) begin
            rsp_vld_d = 1'b0;
`ifdef BTOD_REQ_TIMEOUT_EN
            rsp_err_d = 1'b0;
`endif
        end

        case (state_q)
            StIdle: begin
                if (issue) begin
                    req_d      = 1'b1;
                    req_data_d = mem_q[rd_ptr_q];
`ifdef BTOD_REQ_TIMEOUT_EN
                    tmo_cnt_d  = '0;
`endif
                end
            end
            StReq: begin
                if (ack) begin
                    req_d = 1'b0;
                    if (rsp_full) begin
                        hold_d = ack_data;
                    end else begin
                        rsp_vld_d  = 1'b1;
                        rsp_data_d = ack_data;
`ifdef BTOD_REQ_TIMEOUT_EN
                        rsp_err_d  = 1'b0;
`endif
                    end
                end
`ifdef BTOD_REQ_TIMEOUT_EN
                else if (tmo_hit) begin
                    req_d        = 1'b0;
                    rsp_vld_d    = 1'b1;
                    rsp_data_d   = '0;
                    rsp_err_d    = 1'b1;
                    err_sticky_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            StHold: begin
                if (!rsp_full) begin
                    rsp_vld_d  = 1'b1;
                    rsp_data_d = hold_q;
`ifdef BTOD_REQ_TIMEOUT_EN
                    rsp_err_d  = 1'b0;
`endif
                end
            end
            default: ;
        endcase
    end

    // FIFO storage write.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = cmd_data;
        end
    end

    // FIFO storage: contents need no reset, the count alone marks valid entries.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q        <= 1'b0;
            req_data_q   <= '0;
            rsp_vld_q    <= 1'b0;
            rsp_data_q   <= '0;
            hold_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
`ifdef BTOD_REQ_TIMEOUT_EN
            rsp_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            tmo_cnt_q    <= '0;
`endif
        end else begin
            req_q        <= req_d;
            req_data_q   <= req_data_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_data_q   <= rsp_data_d;
            hold_q       <= hold_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
`ifdef BTOD_REQ_TIMEOUT_EN
            rsp_err_q    <= rsp_err_d;
            err_sticky_q <= err_sticky_d;
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_btod_req_initiator.sv
// Testbench for btod_req_initiator: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model of the channel rules.
module tb_btod_req_initiator;

    localparam int DATA_W  = 32;
    localparam int RSP_W   = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
`ifdef BTOD_REQ_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_vld = 1'b0;
    logic              cmd_rdy;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              req;
    logic [DATA_W-1:0] req_data;
    logic              ack = 1'b0;
    logic [RSP_W-1:0]  ack_data = '0;
    logic              rsp_vld;
    logic              rsp_rdy = 1'b1;
    logic [RSP_W-1:0]  rsp_data;
    logic              rsp_err;
    logic [2:0]        fifo_cnt;
    logic              err_sticky;

    btod_req_initiator #(
        .DATA_W (DATA_W),
        .RSP_W  (RSP_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_vld   (cmd_vld),
        .cmd_rdy   (cmd_rdy),
        .cmd_data  (cmd_data),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .ack_data  (ack_data),
        .rsp_vld   (rsp_vld),
        .rsp_rdy   (rsp_rdy),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .fifo_cnt  (fifo_cnt),
        .err_sticky(err_sticky)
    );

    initial forever #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;
    bit chk_en  = 1'b0;
    bit auto_ack = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queued commands, one outstanding request, a one-deep response slot.
    logic [DATA_W-1:0] m_q[$];
    bit                m_req = 1'b0;
    logic [DATA_W-1:0] m_req_data = '0;
    bit                m_rsp_vld = 1'b0;
    logic [RSP_W-1:0]  m_rsp_data = '0;
    bit                m_rsp_err = 1'b0;
    bit                m_sticky = 1'b0;
    bit                m_gap = 1'b0;
    int                m_wait = 0;

    task automatic model_step();
        bit do_push;
        bit had_rsp;
        if (rst) begin
            m_q.delete();
            m_req      = 1'b0;
            m_req_data = '0;
            m_rsp_vld  = 1'b0;
            m_rsp_data = '0;
            m_rsp_err  = 1'b0;
            m_sticky   = 1'b0;
            m_gap      = 1'b0;
            m_wait     = 0;
        end else begin
            do_push = cmd_vld && (m_q.size() < DEPTH);
            had_rsp = m_rsp_vld;
            if (m_rsp_vld && rsp_rdy) begin
                m_rsp_vld = 1'b0;
                m_rsp_err = 1'b0;
            end
            if (m_req) begin
                if (ack) begin
                    m_req      = 1'b0;
                    m_gap      = 1'b1;
                    m_rsp_vld  = 1'b1;
                    m_rsp_data = ack_data;
                    m_rsp_err  = 1'b0;
                end else if (TmoEn && (m_wait + 1 == TIMEOUT)) begin
                    m_req      = 1'b0;
                    m_gap      = 1'b1;
                    m_rsp_vld  = 1'b1;
                    m_rsp_data = '0;
                    m_rsp_err  = 1'b1;
                    m_sticky   = 1'b1;
                end else begin
                    m_wait++;
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (m_q.size() > 0 && !had_rsp) begin
                m_req      = 1'b1;
                m_req_data = m_q.pop_front();
                m_wait     = 0;
            end
            if (do_push) m_q.push_back(cmd_data);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of every output against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("cmd_rdy", cmd_rdy, !rst && (m_q.size() < DEPTH));
            check("req", req, m_req);
            check("fifo_cnt", fifo_cnt, m_q.size());
            check("rsp_vld", rsp_vld, m_rsp_vld);
            check("rsp_err", rsp_err, m_rsp_err);
            check("err_sticky", err_sticky, m_sticky);
            if (m_req) check("req_data", req_data, m_req_data);
            if (m_rsp_vld) check("rsp_data", rsp_data, m_rsp_data);
            if (rsp_vld && rsp_rdy) hs_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_ack) begin
            ack      = !ack && ($urandom_range(0, 2) == 0);
            ack_data = $urandom;
        end
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (req !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (req !== 1'b1) check("wait_req_expired", req, 1);
    endtask

    task automatic drain();
        int n;
        cmd_vld = 1'b0;
        rsp_rdy = 1'b1;
        auto_ack = 1'b1;
        n = 0;
        while ((fifo_cnt != 0 || req || rsp_vld) && n < 300) begin
            tick();
            n++;
        end
        check("drain_idle", {fifo_cnt != 0, req, rsp_vld}, 0);
        auto_ack = 1'b0;
        ack = 1'b0;
        tick();
    endtask

    initial begin
        int  n;
        int  k;
        bit  acc;

        // Reset values.
        tick();
        tick();
        check("rst_req", req, 0);
        check("rst_req_data", req_data, 0);
        check("rst_rsp_vld", rsp_vld, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_fifo_cnt", fifo_cnt, 0);
        check("rst_err_sticky", err_sticky, 0);
        check("rst_cmd_rdy", cmd_rdy, 0);
        chk_en = 1'b1;
        rst = 1'b0;
        tick();
        check("post_rst_cmd_rdy", cmd_rdy, 1);

        // Single command, ack 3 cycles after req, response then stalled for 10 cycles.
        hs_cnt   = 0;
        rsp_rdy  = 1'b0;
        cmd_vld  = 1'b1;
        cmd_data = 32'hA5A5_0001;
        tick();
        cmd_vld = 1'b0;
        wait_req(n);
        check("push_to_req_cycles", n, 1);
        check("first_req_data", req_data, 32'hA5A5_0001);
        tick();
        tick();
        ack      = 1'b1;
        ack_data = 32'h0000_00C3;
        tick();
        ack = 1'b0;
        check("ack_rsp_vld", rsp_vld, 1);
        check("ack_req_low", req, 0);
        check("ack_rsp_data", rsp_data, 32'hC3);
        check("ack_rsp_err", rsp_err, 0);

        // Burst of 6 while the response is stalled: only DEPTH are accepted.
        k        = 0;
        cmd_vld  = 1'b1;
        cmd_data = 32'h100;
        for (int c = 0; c < 10; c++) begin
            acc = cmd_vld && cmd_rdy;
            tick();
            if (acc) k++;
            cmd_vld  = (k < 6);
            cmd_data = 32'h100 + k;
        end
        check("burst_accepted", k, 4);
        check("burst_fifo_full", fifo_cnt, 4);
        check("burst_cmd_rdy", cmd_rdy, 0);
        check("stall_no_req", req, 0);
        check("stall_rsp_data", rsp_data, 32'hC3);

        // Release: remaining commands go in as space frees, everything answered in order.
        rsp_rdy  = 1'b1;
        auto_ack = 1'b1;
        for (int c = 0; c < 200 && k < 6; c++) begin
            acc = cmd_vld && cmd_rdy;
            tick();
            if (acc) k++;
            cmd_vld  = (k < 6);
            cmd_data = 32'h100 + k;
        end
        check("burst_all_pushed", k, 6);
        drain();
        check("burst_rsp_count", hs_cnt, 7);

        // Spurious ack while idle.
        ack      = 1'b1;
        ack_data = 32'hDEAD;
        tick();
        ack = 1'b0;
        tick();
        check("spur_idle_rsp", rsp_vld, 0);
        check("spur_idle_req", req, 0);

        // Spurious ack during the gap cycle must not overwrite the response.
        rsp_rdy  = 1'b0;
        cmd_vld  = 1'b1;
        cmd_data = 32'h77;
        tick();
        cmd_vld = 1'b0;
        wait_req(n);
        ack      = 1'b1;
        ack_data = 32'h11;
        tick();
        ack_data = 32'h22;
        tick();
        ack = 1'b0;
        check("spur_gap_rsp_vld", rsp_vld, 1);
        check("spur_gap_rsp_data", rsp_data, 32'h11);
        tick();
        check("spur_gap_no_req", req, 0);
        rsp_rdy = 1'b1;
        tick();

        // Reset while a request is outstanding with two commands queued.
        for (int i = 0; i < 3; i++) begin
            cmd_vld  = 1'b1;
            cmd_data = 32'h300 + i;
            tick();
        end
        cmd_vld = 1'b0;
        tick();
        check("pre_rst_fifo_cnt", fifo_cnt, 2);
        check("pre_rst_req", req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_req", req, 0);
        check("mid_rst_fifo_cnt", fifo_cnt, 0);
        check("mid_rst_rsp_vld", rsp_vld, 0);
        repeat (4) tick();
        check("post_rst_no_rsp", rsp_vld, 0);

`ifdef BTOD_REQ_TIMEOUT_EN
        // No ack: request held TIMEOUT cycles, then an error response.
        cmd_vld  = 1'b1;
        cmd_data = 32'h400;
        tick();
        cmd_vld = 1'b0;
        wait_req(n);
        repeat (TIMEOUT - 1) tick();
        check("tmo_req_held", req, 1);
        tick();
        check("tmo_req_drop", req, 0);
        check("tmo_rsp_vld", rsp_vld, 1);
        check("tmo_rsp_err", rsp_err, 1);
        check("tmo_rsp_data", rsp_data, 0);
        check("tmo_sticky", err_sticky, 1);
        tick();
        // Ack on the TIMEOUT-th cycle wins.
        cmd_vld  = 1'b1;
        cmd_data = 32'h401;
        tick();
        cmd_vld = 1'b0;
        wait_req(n);
        repeat (TIMEOUT - 1) tick();
        ack      = 1'b1;
        ack_data = 32'h5A;
        tick();
        ack = 1'b0;
        check("tmo_race_rsp_vld", rsp_vld, 1);
        check("tmo_race_rsp_err", rsp_err, 0);
        check("tmo_race_rsp_data", rsp_data, 32'h5A);
        check("tmo_race_sticky", err_sticky, 1);
        tick();
`else
        // Without the timeout the request waits indefinitely.
        cmd_vld  = 1'b1;
        cmd_data = 32'h400;
        tick();
        cmd_vld = 1'b0;
        wait_req(n);
        repeat (20) tick();
        check("long_wait_req", req, 1);
        check("long_wait_rsp", rsp_vld, 0);
        ack      = 1'b1;
        ack_data = 32'h5A;
        tick();
        ack = 1'b0;
        check("long_wait_rsp_data", rsp_data, 32'h5A);
        check("long_wait_rsp_err", rsp_err, 0);
        tick();
`endif

        // Randomized traffic with occasional resets.
        auto_ack = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            cmd_vld  = ($urandom_range(0, 1) == 1);
            cmd_data = $urandom;
            rsp_rdy  = ($urandom_range(0, 3) != 0);
            rst      = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
